// File: rtl/pll_lock_ctrl.sv
// PLL feedback-divider sequencer and lock detector: arms the divider, then compares
// reference and feedback edge counts over fixed reference windows to declare lock.
module pll_lock_ctrl #(
  parameter int DIV_W     = 4,
  parameter int CNT_W     = 8,
  parameter int WIN_LEN   = 64,
  parameter int TOL       = 1,
  parameter int LOCK_WINS = 4,
  parameter int ARM_CYC   = 16
) (
  input  logic             clk_out,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] div_cfg,
  input  logic             ref_in,
  input  logic             fb_in,
  output logic             div_rst_n,
  output logic [DIV_W-1:0] div_n,
  output logic             locked,
  output logic             lock_lost,
  output logic             cfg_err,
  output logic [1:0]       state
);

  localparam int ARM_W  = $clog2(ARM_CYC + 1);
  localparam int GOOD_W = $clog2(LOCK_WINS + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  WIN_LAST  = CNT_W'(WIN_LEN - 1);
  localparam logic [ARM_W-1:0]  ARM_LAST  = ARM_W'(ARM_CYC - 1);
  localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_WINS);
  localparam logic signed [CNT_W:0] WIN_S = (CNT_W+1)'(WIN_LEN);
  localparam logic signed [CNT_W:0] TOL_S = (CNT_W+1)'(TOL);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2,
    ST_LOCK = 2'd3
  } state_t;

  // Window quality: signed distance of the feedback count from the nominal window length.
  function automatic logic win_good(input logic [CNT_W-1:0] fb_total);
    logic signed [CNT_W:0] diff;
    diff = $signed({1'b0, fb_total}) - WIN_S;
    return (diff <= TOL_S) && (diff >= -TOL_S);
  endfunction

  state_t             state_q, state_d;
  logic [2:0]         ref_sh_q, ref_sh_d, fb_sh_q, fb_sh_d;
  logic [DIV_W-1:0]   div_n_q, div_n_d;
  logic [ARM_W-1:0]   arm_cnt_q, arm_cnt_d;
  logic [CNT_W-1:0]   ref_cnt_q, ref_cnt_d, fb_cnt_q, fb_cnt_d;
  logic [GOOD_W-1:0]  good_wins_q, good_wins_d;
  logic               div_rst_n_q, div_rst_n_d;
  logic               locked_q, locked_d;
  logic               lock_lost_q, lock_lost_d;
  logic               cfg_err_q, cfg_err_d;
  logic               ref_rise, fb_rise, win_end, win_ok;
  logic [CNT_W-1:0]   fb_sum;
  logic [GOOD_W-1:0]  good_inc;

  // Two synchroniser stages plus one edge-detect stage per asynchronous input.
  always_comb begin
    ref_sh_d = {ref_sh_q[1:0], ref_in};
    fb_sh_d  = {fb_sh_q[1:0], fb_in};
    ref_rise = ref_sh_q[1] & ~ref_sh_q[2];
    fb_rise  = fb_sh_q[1] & ~fb_sh_q[2];
    fb_sum   = (fb_rise && (fb_cnt_q != CNT_MAX)) ? fb_cnt_q + CNT_W'(1) : fb_cnt_q;
    win_end  = ref_rise && (ref_cnt_q == WIN_LAST);
    win_ok   = win_good(fb_sum);
    good_inc = (good_wins_q < GOOD_LOCK) ? good_wins_q + GOOD_W'(1) : good_wins_q;
  end

  // Sequencer next state, window bookkeeping and registered-output next values.
  always_comb begin
    state_d     = state_q;
    div_n_d     = div_n_q;
    arm_cnt_d   = arm_cnt_q;
    ref_cnt_d   = ref_cnt_q;
    fb_cnt_d    = fb_cnt_q;
    good_wins_d = good_wins_q;
    cfg_err_d   = 1'b0;
    lock_lost_d = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && (div_cfg >= DIV_W'(2))) begin
            div_n_d   = div_cfg;
            arm_cnt_d = '0;
            state_d   = ST_ARM;
          end else begin
            cfg_err_d = start;
          end
        end
        ST_ARM: begin
          if (arm_cnt_q == ARM_LAST) begin
            state_d     = ST_MEAS;
            ref_cnt_d   = '0;
            fb_cnt_d    = '0;
            good_wins_d = '0;
          end else begin
            arm_cnt_d = arm_cnt_q + ARM_W'(1);
          end
        end
        ST_MEAS, ST_LOCK: begin
          if (win_end) begin
            // Edges seen on the closing cycle belong to the window just ending.
            ref_cnt_d = '0;
            fb_cnt_d  = '0;
            if (win_ok) begin
              if (state_q == ST_MEAS) begin
                good_wins_d = good_inc;
                state_d     = (good_inc == GOOD_LOCK) ? ST_LOCK : ST_MEAS;
              end else begin
                state_d = ST_LOCK;
              end
            end else begin
              good_wins_d = '0;
              state_d     = ST_MEAS;
              lock_lost_d = (state_q == ST_LOCK);
            end
          end else begin
            ref_cnt_d = ref_cnt_q + CNT_W'(ref_rise);
            fb_cnt_d  = fb_sum;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    locked_d    = (state_d == ST_LOCK);
    div_rst_n_d = (state_d == ST_MEAS) || (state_d == ST_LOCK);
  end

  // State, counters, synchronisers and outputs.
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ref_sh_q    <= 3'b000;
      fb_sh_q     <= 3'b000;
      div_n_q     <= '0;
      arm_cnt_q   <= '0;
      ref_cnt_q   <= '0;
      fb_cnt_q    <= '0;
      good_wins_q <= '0;
      div_rst_n_q <= 1'b0;
      locked_q    <= 1'b0;
      lock_lost_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ref_sh_q    <= ref_sh_d;
      fb_sh_q     <= fb_sh_d;
      div_n_q     <= div_n_d;
      arm_cnt_q   <= arm_cnt_d;
      ref_cnt_q   <= ref_cnt_d;
      fb_cnt_q    <= fb_cnt_d;
      good_wins_q <= good_wins_d;
      div_rst_n_q <= div_rst_n_d;
      locked_q    <= locked_d;
      lock_lost_q <= lock_lost_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign state     = state_q;
  assign div_n     = div_n_q;
  assign div_rst_n = div_rst_n_q;
  assign locked    = locked_q;
  assign lock_lost = lock_lost_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Bench for pll_lock_ctrl: IDLE vector table, directed lock/loss/abort/reset sequences,
// and randomized stimulus, all checked against a cycle-level reference model.
module tb_pll_lock_ctrl;
  localparam int RP = 6;

  logic       clk_out = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic       ref_in = 1'b0, fb_in = 1'b0;
  logic [3:0] div_cfg = 4'd0;
  logic       div_rst_n, locked, lock_lost, cfg_err;
  logic [3:0] div_n;
  logic [1:0] state;

  int errors = 0, checks = 0;

  pll_lock_ctrl dut (
    .clk_out(clk_out), .rst_n(rst_n), .start(start), .abort(abort), .div_cfg(div_cfg),
    .ref_in(ref_in), .fb_in(fb_in), .div_rst_n(div_rst_n), .div_n(div_n),
    .locked(locked), .lock_lost(lock_lost), .cfg_err(cfg_err), .state(state)
  );

  always #5 clk_out = ~clk_out;

  // Waveform generator: fixed reference period, feedback period switchable at its own wrap.
  int rph = 0, fph = 0, fp = RP, fb_norm = RP, fb_extra = 0;

  // Reference model: 0=IDLE 1=ARM 2=MEASURE 3=LOCKED.
  int m_state, m_div_n, m_dr, m_locked, m_lost, m_cfg, m_arm, m_refc, m_fbc, m_good, m_wins;
  bit hr[3], hf[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_div_n = 0; m_dr = 0; m_locked = 0; m_lost = 0; m_cfg = 0;
    m_arm = 0; m_refc = 0; m_fbc = 0; m_good = 0; m_wins = 0;
    for (int i = 0; i < 3; i++) begin hr[i] = 1'b0; hf[i] = 1'b0; end
  endtask

  // One clock edge: a rise is counted when the input was 1 two edges ago and 0 three edges ago.
  task automatic model_step(input bit s, input bit a, input int cfg, input bit r, input bit f);
    bit rr, rf, good;
    rr = hr[1] & !hr[2];
    rf = hf[1] & !hf[2];
    hr[2] = hr[1]; hr[1] = hr[0]; hr[0] = r;
    hf[2] = hf[1]; hf[1] = hf[0]; hf[0] = f;
    m_lost = 0; m_cfg = 0;
    if (a) m_state = 0;
    else if (m_state == 0) begin
      if (s && cfg >= 2) begin m_div_n = cfg; m_arm = 0; m_state = 1; end
      else if (s) m_cfg = 1;
    end else if (m_state == 1) begin
      m_arm++;
      if (m_arm == 16) begin m_state = 2; m_refc = 0; m_fbc = 0; m_good = 0; end
    end else begin
      m_refc += int'(rr);
      m_fbc  += int'(rf);
      if (m_fbc > 255) m_fbc = 255;
      if (m_refc == 64) begin
        m_wins++;
        good = (m_fbc - 64 <= 1) && (64 - m_fbc <= 1);
        m_refc = 0; m_fbc = 0;
        if (good) begin
          if (m_state == 2) begin
            if (m_good < 4) m_good++;
            if (m_good == 4) m_state = 3;
          end
        end else begin
          m_good = 0;
          if (m_state == 3) begin m_state = 2; m_lost = 1; end
        end
      end
    end
    m_locked = (m_state == 3);
    m_dr     = (m_state >= 2);
  endtask

  task automatic tick();
    ref_in = (rph < RP / 2);
    fb_in  = (fph < fp / 2);
    @(posedge clk_out); #1;
    model_step(start, abort, int'(div_cfg), ref_in, fb_in);
    rph = (rph + 1) % RP;
    fph++;
    if (fph == fp) begin
      fph = 0;
      if (fb_extra > 0) begin fp = 4; fb_extra--; end
      else fp = fb_norm;
    end
    chk("state", state, m_state);
    chk("div_n", div_n, m_div_n);
    chk("div_rst_n", div_rst_n, m_dr);
    chk("locked", locked, m_locked);
    chk("lock_lost", lock_lost, m_lost);
    chk("cfg_err", cfg_err, m_cfg);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_out);
    #1;
    chk("rst_state", state, 0);
    chk("rst_div_rst_n", div_rst_n, 0);
    chk("rst_div_n", div_n, 0);
    chk("rst_locked", locked, 0);
    chk("rst_flags", {lock_lost, cfg_err}, 0);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start(input logic [3:0] cfg);
    div_cfg = cfg; start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic run_until_lock(input int budget);
    int n;
    n = 0;
    while (!locked && n < budget) begin tick(); n++; end
    chk("lock_reached", locked, 1);
  endtask

  task automatic wait_win_end();
    int w, n;
    w = m_wins; n = 0;
    while (m_wins == w && n < 2000) begin tick(); n++; end
    chk("window_end_seen", (m_wins != w), 1);
  endtask

  typedef struct {
    bit st; bit ab; logic [3:0] cfg;
    logic [1:0] e_state; bit e_cfg_err; logic [3:0] e_div_n; bit e_dr;
  } vec_t;
  vec_t tbl[10];

  initial begin
    int n, w0, w_loss, lost_cnt;
    tbl[0] = '{1'b1, 1'b0, 4'd1,  2'd0, 1'b1, 4'd0,  1'b0};
    tbl[1] = '{1'b0, 1'b0, 4'd1,  2'd0, 1'b0, 4'd0,  1'b0};
    tbl[2] = '{1'b1, 1'b0, 4'd0,  2'd0, 1'b1, 4'd0,  1'b0};
    tbl[3] = '{1'b0, 1'b0, 4'd7,  2'd0, 1'b0, 4'd0,  1'b0};
    tbl[4] = '{1'b1, 1'b0, 4'd7,  2'd1, 1'b0, 4'd7,  1'b0};
    tbl[5] = '{1'b1, 1'b0, 4'd3,  2'd1, 1'b0, 4'd7,  1'b0};
    tbl[6] = '{1'b1, 1'b1, 4'd9,  2'd0, 1'b0, 4'd7,  1'b0};
    tbl[7] = '{1'b1, 1'b0, 4'd1,  2'd0, 1'b1, 4'd7,  1'b0};
    tbl[8] = '{1'b1, 1'b0, 4'd15, 2'd1, 1'b0, 4'd15, 1'b0};
    tbl[9] = '{1'b0, 1'b1, 4'd2,  2'd0, 1'b0, 4'd15, 1'b0};

    // IDLE handling: cfg_err, latching, ignored start, abort priority.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      start = tbl[i].st; abort = tbl[i].ab; div_cfg = tbl[i].cfg;
      tick();
      chk($sformatf("vec%0d_state", i), state, tbl[i].e_state);
      chk($sformatf("vec%0d_cfg_err", i), cfg_err, tbl[i].e_cfg_err);
      chk($sformatf("vec%0d_div_n", i), div_n, tbl[i].e_div_n);
      chk($sformatf("vec%0d_div_rst_n", i), div_rst_n, tbl[i].e_dr);
    end
    start = 1'b0; abort = 1'b0;

    // Arm for exactly 16 cycles, then lock after four good windows.
    do_reset();
    pulse_start(4'd10);
    n = 0;
    while (state == 2'd1 && n < 40) begin
      if (!div_rst_n) n++;
      tick();
    end
    chk("arm_low_cycles", n, 16);
    chk("measure_div_rst_n", div_rst_n, 1);
    w0 = m_wins;
    run_until_lock(6 * 64 * RP);
    chk("windows_to_lock", m_wins - w0, 4);
    chk("locked_div_n", div_n, 10);

    // Three extra feedback edges inside one window while locked.
    wait_win_end();
    fb_extra = 9;
    lost_cnt = 0; w_loss = -1;
    for (int i = 0; i < 2 * 64 * RP; i++) begin
      tick();
      if (lock_lost) begin lost_cnt++; w_loss = m_wins; end
    end
    chk("lock_lost_pulses", lost_cnt, 1);
    chk("unlocked_after_loss", locked, 0);
    run_until_lock(6 * 64 * RP);
    chk("windows_to_relock", m_wins - w_loss, 4);

    // good, good, bad, then four goods: lock on the 7th window.
    do_reset();
    pulse_start(4'd10);
    repeat (16) tick();
    w0 = m_wins;
    wait_win_end();
    wait_win_end();
    fb_extra = 9;
    run_until_lock(9 * 64 * RP);
    chk("lock_window_index", m_wins - w0, 7);

    // Abort mid-ARM and while LOCKED.
    pulse_start(4'd6);
    abort = 1'b1; tick(); abort = 1'b0;
    pulse_start(4'd6);
    repeat (5) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_arm_state", state, 0);
    chk("abort_arm_div_rst_n", div_rst_n, 0);
    pulse_start(4'd6);
    run_until_lock(6 * 64 * RP);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_lock_state", state, 0);
    chk("abort_lock_locked", locked, 0);
    chk("abort_lock_lost", lock_lost, 0);
    chk("abort_lock_div_rst_n", div_rst_n, 0);

    // Asynchronous reset while LOCKED, then a normal restart.
    pulse_start(4'd6);
    run_until_lock(6 * 64 * RP);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_locked", locked, 0);
    chk("async_rst_div_rst_n", div_rst_n, 0);
    chk("async_rst_div_n", div_n, 0);
    do_reset();
    pulse_start(4'd5);
    run_until_lock(6 * 64 * RP);
    chk("restart_div_n", div_n, 5);

    // Randomized traffic: starts, rare aborts, feedback period and burst disturbances.
    do_reset();
    for (int i = 0; i < 12000; i++) begin
      start = ($urandom_range(0, 29) == 0);
      abort = ($urandom_range(0, 2999) == 0);
      div_cfg = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 399) == 0) begin
        case ($urandom_range(0, 4))
          0: fb_norm = 5;
          1: fb_norm = 7;
          default: fb_norm = RP;
        endcase
      end
      if ($urandom_range(0, 599) == 0) fb_extra = $urandom_range(1, 6);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
